turbo_rsc_encoder: RTL and testbench

TURBO_RSC_ENCODER -- requirements
Module: turbo_rsc_encoder

---
 rtl/turbo_pkg.sv | 14 +
 rtl/rsc_encoder.sv | 30 +++
 rtl/turbo_rsc_encoder.sv | 164 ++++++++++++++++
 tb/tb_turbo_rsc_encoder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// rtl/turbo_pkg.sv - shared constants and FSM state type for the turbo RSC encoder
package turbo_pkg;
  localparam int K_1056        = 1056;
  localparam int K_6144        = 6144;
  localparam int TAIL_LEN      = 3;
  localparam int CNT_W_DEFAULT = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TAIL1 = 2'd2,
    TAIL2 = 2'd3
  } state_t;
endpackage

// File: rtl/rsc_encoder.sv
// rtl/rsc_encoder.sv - 8-state recursive systematic convolutional constituent encoder
module rsc_encoder (
  input  logic clk,
  input  logic clear,
  input  logic zero,
  input  logic en,
  input  logic term,
  input  logic u,
  output logic z,
  output logic x
);
  // r[2]=r1, r[1]=r2, r[0]=r3
  logic [2:0] r;
  logic       a;

  // During termination the input cancels the feedback, so the register drains to zero
  assign x = term ? (r[1] ^ r[0]) : u;
  assign a = x ^ r[1] ^ r[0];
  assign z = a ^ r[2] ^ r[0];

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r <= 3'b000;
    end else if (zero) begin
      r <= 3'b000;
    end else if (en) begin
      r <= {a, r[2], r[1]};
    end
  end
endmodule

// File: rtl/turbo_rsc_encoder.sv
// rtl/turbo_rsc_encoder.sv - dual RSC turbo encoder core; TRELLIS_TERM_EN adds trellis termination
module turbo_rsc_encoder
  import turbo_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic clear,
  input  logic k_size_6144,
  input  logic start,
  input  logic in_valid,
  input  logic ci,
  input  logic cpii,
  output logic out_valid,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic tail,
  output logic busy,
  output logic done
);
  localparam logic [CNT_W-1:0] LAST_1056 = CNT_W'(K_1056 - 1);
  localparam logic [CNT_W-1:0] LAST_6144 = CNT_W'(K_6144 - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, k_last;
  logic             k_sel, k_sel_n;
  logic             ov_n, d0_n, d1_n, d2_n, done_n;
  logic             en1, en2, term1, term2, zero;
  logic             z1, z2, x1, x2;

  assign k_last = k_sel ? LAST_6144 : LAST_1056;
  assign busy   = (state != IDLE) | done;

  rsc_encoder u_enc1 (
    .clk(clk), .clear(clear), .zero(zero), .en(en1), .term(term1),
    .u(ci), .z(z1), .x(x1)
  );

  rsc_encoder u_enc2 (
    .clk(clk), .clear(clear), .zero(zero), .en(en2), .term(term2),
    .u(cpii), .z(z2), .x(x2)
  );

`ifdef TRELLIS_TERM_EN
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_LEN - 1);
  logic tail_n;
`else
  logic unused_x2;
  assign unused_x2 = x2;
  assign tail      = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    k_sel_n = k_sel;
    ov_n    = 1'b0;
    d0_n    = 1'b0;
    d1_n    = 1'b0;
    d2_n    = 1'b0;
    done_n  = 1'b0;
    en1     = 1'b0;
    en2     = 1'b0;
    term1   = 1'b0;
    term2   = 1'b0;
    zero    = 1'b0;
`ifdef TRELLIS_TERM_EN
    tail_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          k_sel_n = k_size_6144;
          cnt_n   = '0;
          zero    = 1'b1;
          state_n = DATA;
        end
      end
      DATA: begin
        if (in_valid) begin
          en1   = 1'b1;
          en2   = 1'b1;
          ov_n  = 1'b1;
          d0_n  = x1;
          d1_n  = z1;
          d2_n  = z2;
          cnt_n = cnt + 1'b1;
          if (cnt == k_last) begin
            cnt_n = '0;
`ifdef TRELLIS_TERM_EN
            state_n = TAIL1;
`else
            state_n = IDLE;
            done_n  = 1'b1;
`endif
          end
        end
      end
`ifdef TRELLIS_TERM_EN
      TAIL1: begin
        en1    = 1'b1;
        term1  = 1'b1;
        ov_n   = 1'b1;
        d0_n   = x1;
        d1_n   = z1;
        tail_n = 1'b1;
        cnt_n  = cnt + 1'b1;
        if (cnt == TAIL_LAST) begin
          cnt_n   = '0;
          state_n = TAIL2;
        end
      end
      TAIL2: begin
        en2    = 1'b1;
        term2  = 1'b1;
        ov_n   = 1'b1;
        d0_n   = x2;
        d1_n   = z2;
        tail_n = 1'b1;
        cnt_n  = cnt + 1'b1;
        if (cnt == TAIL_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      k_sel     <= 1'b0;
      out_valid <= 1'b0;
      d0        <= 1'b0;
      d1        <= 1'b0;
      d2        <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      k_sel     <= k_sel_n;
      out_valid <= ov_n;
      d0        <= d0_n;
      d1        <= d1_n;
      d2        <= d2_n;
      done      <= done_n;
    end
  end

`ifdef TRELLIS_TERM_EN
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      tail <= 1'b0;
    end else begin
      tail <= tail_n;
    end
  end
`endif
endmodule

// File: tb/tb_turbo_rsc_encoder.sv
// tb/tb_turbo_rsc_encoder.sv - self-checking bench for turbo_rsc_encoder against a queue-based reference model
module tb_turbo_rsc_encoder;
`ifdef TRELLIS_TERM_EN
  localparam bit TERM = 1'b1;
`else
  localparam bit TERM = 1'b0;
`endif
  localparam int TAILS = TERM ? 6 : 0;

  logic clk = 1'b0, clear = 1'b1, k_size_6144 = 1'b0, start = 1'b0;
  logic in_valid = 1'b0, ci = 1'b0, cpii = 1'b0;
  logic out_valid, d0, d1, d2, tail, busy, done;

  int         n_checks = 0, n_fail = 0;
  logic [4:0] expq[$];
  int         blk_valid, blk_done, blk_tail, blk_d2_data, cap_n;
  logic [4:0] cap;
  logic [2:0] s1, s2;

  turbo_rsc_encoder #(.CNT_W(13)) dut (
    .clk(clk), .clear(clear), .k_size_6144(k_size_6144), .start(start),
    .in_valid(in_valid), .ci(ci), .cpii(cpii), .out_valid(out_valid),
    .d0(d0), .d1(d1), .d2(d2), .tail(tail), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Constituent code: feedback 1+D^2+D^3, parity 1+D+D^3; state packed {r1,r2,r3}
  function automatic logic [3:0] enc_step(input logic [2:0] s, input logic u);
    logic a, z;
    a = u ^ s[1] ^ s[0];
    z = a ^ s[2] ^ s[0];
    return {z, a, s[2], s[1]};
  endfunction

  task automatic model_push(input logic c, input logic p, input bit last);
    logic z1, z2, u, z;
    {z1, s1} = enc_step(s1, c);
    {z2, s2} = enc_step(s2, p);
    expq.push_back({c, z1, z2, 1'b0, last && !TERM});
    if (last && TERM) begin
      for (int j = 0; j < 3; j++) begin
        u = s1[1] ^ s1[0];
        {z, s1} = enc_step(s1, u);
        expq.push_back({u, z, 1'b0, 1'b1, 1'b0});
      end
      for (int j = 0; j < 3; j++) begin
        u = s2[1] ^ s2[0];
        {z, s2} = enc_step(s2, u);
        expq.push_back({u, z, 1'b0, 1'b1, j == 2});
      end
      chk("model_term_state", {26'd0, s1, s2}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      blk_valid++;
      if (tail) blk_tail++;
      if (done) blk_done++;
      if (!tail && d2) blk_d2_data++;
      if (cap_n < 5) begin
        cap = {cap[3:0], d1};
        cap_n++;
      end
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output actual=%0b%0b%0b expected=none", d0, d1, d2);
      end else begin
        chk("out_bits", {27'd0, d0, d1, d2, tail, done}, {27'd0, expq.pop_front()});
      end
    end else begin
      chk("idle_outputs_zero", {27'd0, d0, d1, d2, tail, done}, 32'd0);
    end
  end

  // mode: 0 all-zero, 1 single one at bit 0, 2 valid pattern 1001, 3 random with stalls, 4 random dense
  task automatic run_block(input bit k6, input int mode, input int clear_at, input bit odd_start);
    int  k, i, slot, t;
    bit  v;
    logic c, p;
    k = k6 ? 6144 : 1056;
    blk_valid = 0; blk_done = 0; blk_tail = 0; blk_d2_data = 0; cap_n = 0; cap = '0;
    s1 = '0; s2 = '0;
    @(posedge clk); #1;
    start = 1'b1; k_size_6144 = k6;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    i = 0; slot = 0;
    while (i < k) begin
      case (mode)
        2:       v = (slot % 4 == 0) || (slot % 4 == 3);
        3:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      slot++;
      case (mode)
        0:       begin c = 1'b0; p = 1'b0; end
        1:       begin c = (i == 0); p = 1'b0; end
        default: begin c = 1'($urandom); p = 1'($urandom); end
      endcase
      in_valid = v;
      ci   = v ? c : 1'($urandom);
      cpii = v ? p : 1'($urandom);
      start = odd_start && (i == 500);
      if (odd_start) k_size_6144 = ~k_size_6144;
      if (v) begin
        model_push(c, p, i == k - 1);
        i++;
      end
      @(posedge clk); #1;
      if (i == clear_at) begin
        clear = 1'b1;
        expq.delete();
        in_valid = 1'b0; start = 1'b0;
        #1;
        chk("clear_busy", {31'd0, busy}, 32'd0);
        chk("clear_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_valid_count", blk_valid, 299);
        chk("clear_no_done", blk_done, 0);
        return;
      end
    end
    in_valid = 1'b0; start = 1'b0; k_size_6144 = 1'b0;
    t = 0;
    while (busy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("block_end_timeout", {31'd0, busy}, 32'd0);
    chk("valid_count", blk_valid, k + TAILS);
    chk("done_count", blk_done, 1);
    chk("tail_count", blk_tail, TAILS);
    chk("queue_drained", expq.size(), 0);
`ifdef TRELLIS_TERM_EN
    chk("enc_state_zero", {26'd0, dut.u_enc1.r, dut.u_enc2.r}, 32'd0);
`endif
  endtask

  initial begin
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done_tail", {30'd0, done, tail}, 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;

    run_block(1'b0, 0, -1, 1'b0);
    chk("all_zero_total", blk_valid, 1056 + TAILS);
    run_block(1'b0, 1, -1, 1'b0);
    chk("impulse_d1_first5", {27'd0, cap}, 32'b11110);
    chk("impulse_d2_data_zero", blk_d2_data, 0);
    run_block(1'b0, 2, -1, 1'b0);
    run_block(1'b1, 3, -1, 1'b0);
    chk("k6144_total", blk_valid, 6144 + TAILS);
    run_block(1'b0, 4, -1, 1'b1);
    chk("ignored_start_total", blk_valid, 1056 + TAILS);
    run_block(1'b0, 4, 300, 1'b0);
    run_block(1'b0, 3, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
